// File: rtl/tick_pwm_if.sv
// Control/status bundle between a tick_pwm and its owner.
interface tick_pwm_if #(
  parameter int CW = 4
);
  logic          enable;
  logic          tick_src;
  logic [CW-1:0] duty;
  logic          pwm;
  logic          period_start;
  logic [CW-1:0] phase;

  modport master (
    output enable, tick_src, duty,
    input  pwm, period_start, phase
  );

  modport slave (
    input  enable, tick_src, duty,
    output pwm, period_start, phase
  );
endinterface

// File: rtl/tick_pwm_rise_detect.sv
// Single-register rising-edge detector for a same-domain tick source.
module rise_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic prev_r;

  // Reset loads the live input so a source already high at release is not a rise.
  always_ff @(posedge clk_in) begin
    prev_r <= din;
  end

  assign rise = din & ~prev_r & ~reset;
endmodule

// File: rtl/tick_pwm.sv
// Tick-driven PWM: phase counter over PERIOD ticks, duty latched at period wrap.
module tick_pwm #(
  parameter int PERIOD = 10,
  parameter int CW     = $clog2(PERIOD + 1)
) (
  input logic       clk_in,
  input logic       reset,
  tick_pwm_if.slave bus
);
  localparam logic [CW-1:0] PER_C  = CW'(PERIOD);
  localparam logic [CW-1:0] LAST_C = CW'(PERIOD - 1);

  function automatic logic [CW-1:0] sat_duty(input logic [CW-1:0] d);
    return (d > PER_C) ? PER_C : d;
  endfunction

  logic          rise;
  logic [CW-1:0] dsat;
  logic [CW-1:0] phase_r;
  logic [CW-1:0] phase_inc;
  logic [CW-1:0] duty_active;
  logic          pwm_r;
  logic          ps_r;

  rise_detect u_rise (
    .clk_in (clk_in),
    .reset  (reset),
    .din    (bus.tick_src),
    .rise   (rise)
  );

  assign dsat      = sat_duty(bus.duty);
  assign phase_inc = phase_r + CW'(1);

  // Disabled tracks the request every cycle so enabling starts on the current duty.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      phase_r     <= '0;
      duty_active <= '0;
      pwm_r       <= 1'b0;
      ps_r        <= 1'b0;
    end else if (!bus.enable) begin
      phase_r     <= '0;
      duty_active <= dsat;
      pwm_r       <= 1'b0;
      ps_r        <= 1'b0;
    end else if (rise) begin
      if (phase_r == LAST_C) begin
        phase_r     <= '0;
        duty_active <= dsat;
        pwm_r       <= (dsat != '0);
        ps_r        <= 1'b1;
      end else begin
        phase_r <= phase_inc;
        pwm_r   <= (phase_inc < duty_active);
        ps_r    <= 1'b0;
      end
    end else begin
      pwm_r <= (phase_r < duty_active);
      ps_r  <= 1'b0;
    end
  end

  assign bus.pwm          = pwm_r;
  assign bus.period_start = ps_r;
  assign bus.phase        = phase_r;
endmodule

// File: tb/tb_tick_pwm.sv
// Randomized + scenario bench for tick_pwm (PERIOD=4) against a behavioural model.
module tb_tick_pwm;
  localparam int P  = 4;
  localparam int CW = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  bit          rst = 1'b1;
  bit          en  = 1'b0;
  bit          tk  = 1'b0;
  logic [CW-1:0] dt = '0;

  tick_pwm_if #(.CW(CW)) bus ();
  assign bus.enable   = en;
  assign bus.tick_src = tk;
  assign bus.duty     = dt;

  tick_pwm #(.PERIOD(P), .CW(CW)) dut (
    .clk_in (clk_in),
    .reset  (rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int d);
    return (d > P) ? P : d;
  endfunction

  // Reference: count rises modulo P, duty snapshot taken at each period start.
  bit m_prev = 1'b0;
  int m_ph   = 0;
  int m_duty = 0;
  bit m_pwm  = 1'b0;
  bit m_ps   = 1'b0;

  always @(posedge clk_in) begin
    m_prev <= tk;
    if (rst) begin
      m_ph <= 0; m_duty <= 0; m_pwm <= 1'b0; m_ps <= 1'b0;
    end else if (!en) begin
      m_ph <= 0; m_duty <= sat(int'(dt)); m_pwm <= 1'b0; m_ps <= 1'b0;
    end else if (tk && !m_prev) begin
      if ((m_ph + 1) % P == 0) begin
        m_ph <= 0; m_duty <= sat(int'(dt)); m_ps <= 1'b1;
        m_pwm <= (sat(int'(dt)) > 0);
      end else begin
        m_ph <= m_ph + 1; m_ps <= 1'b0;
        m_pwm <= (m_ph + 1 < m_duty);
      end
    end else begin
      m_ps  <= 1'b0;
      m_pwm <= (m_ph < m_duty);
    end
  end

  int o_pwm, o_ps, o_ph;
  bit auto_tick = 1'b0;
  int tcnt = 0;
  bit mid_change = 1'b0;

  task automatic step();
    @(negedge clk_in);
    o_pwm = int'(bus.pwm);
    o_ps  = int'(bus.period_start);
    o_ph  = int'(bus.phase);
    chk("model_pwm",   o_pwm, int'(m_pwm));
    chk("model_ps",    o_ps,  int'(m_ps));
    chk("model_phase", o_ph,  m_ph);
    if (auto_tick) begin
      tcnt++;
      if (tcnt == 2) begin tcnt = 0; tk = ~tk; end
    end
  endtask

  // Window of n cycles starting at the cycle that shows period_start.
  task automatic count_from_ps(input int n, output int hi, output int np);
    int t;
    t = 0;
    step();
    while (!o_ps && t < 64) begin step(); t++; end
    if (!o_ps) chk("ps_timeout", 0, 1);
    hi = o_pwm; np = 1;
    for (int i = 1; i < n; i++) begin
      if (mid_change && o_ph == 2) begin dt = 3'd3; mid_change = 1'b0; end
      step();
      hi += o_pwm; np += o_ps;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, np, t;
    bit old;

    repeat (3) step();
    chk("rst_pwm", o_pwm, 0);
    chk("rst_ps", o_ps, 0);
    chk("rst_phase", o_ph, 0);

    rst = 1'b0; dt = 3'd1; en = 1'b1; auto_tick = 1'b1;
    count_from_ps(16, hi, np);
    count_from_ps(16, hi, np);
    chk("steady_hi", hi, 4);
    chk("steady_ps", np, 1);

    dt = 3'd0; count_from_ps(16, hi, np); chk("duty0_hi", hi, 0);
    dt = 3'd4; count_from_ps(16, hi, np); chk("duty4_hi", hi, 16);
    dt = 3'd7; count_from_ps(16, hi, np); chk("duty7_hi", hi, 16);

    dt = 3'd1; count_from_ps(16, hi, np);
    mid_change = 1'b1;
    count_from_ps(16, hi, np); chk("mid_cur_hi", hi, 4);
    count_from_ps(16, hi, np); chk("mid_next_hi", hi, 12);

    // Drop enable exactly when a rise is pending at phase 2.
    t = 0;
    do begin old = tk; step(); t++; end while (!(o_ph == 2 && tk && !old) && t < 64);
    chk("dis_found", int'(o_ph == 2 && tk && !old), 1);
    en = 1'b0;
    step();
    chk("dis_phase", o_ph, 0);
    chk("dis_pwm", o_pwm, 0);
    dt = 3'd2; step();
    en = 1'b1; step();
    chk("en_pwm", o_pwm, 1);
    chk("en_ps", o_ps, 0);

    t = 0;
    do begin step(); t++; end while (o_ph != 2 && t < 64);
    chk("rst_pre_phase", o_ph, 2);
    auto_tick = 1'b0; tk = 1'b1; rst = 1'b1;
    step();
    chk("rst_mid_pwm", o_pwm, 0);
    chk("rst_mid_ps", o_ps, 0);
    chk("rst_mid_phase", o_ph, 0);
    rst = 1'b0;
    step(); step();
    chk("rst_norise", o_ph, 0);
    tk = 1'b0; step();
    tk = 1'b1; step();
    chk("rst_first_rise", o_ph, 1);

    for (int k = 0; k < 8; k++) begin
      tk = 1'b0; step();
      tk = 1'b1; step();
      chk("pulse_phase", o_ph, (2 + k) % P);
    end

    for (int i = 0; i < 400; i++) begin
      tk  = 1'($urandom_range(0, 1));
      en  = ($urandom % 8) != 0;
      dt  = CW'($urandom_range(0, 7));
      rst = ($urandom % 50) == 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
